// File: rtl/sys_ctrl_pkg.sv
// Shared constants for the system-control UART protocol (host and responder).
package sys_ctrl_pkg;

  typedef logic [7:0] sc_byte_t;

  // Command opcodes
  localparam sc_byte_t HALT_CPU   = 8'h00;
  localparam sc_byte_t RESUME_CPU = 8'h01;
  localparam sc_byte_t WRITE_MEM  = 8'h02;
  localparam sc_byte_t READ_MEM   = 8'h03;
  localparam sc_byte_t RESET_CPU  = 8'h04;
  localparam sc_byte_t PING       = 8'h05;

  // Response bytes
  localparam sc_byte_t ACK_BYTE    = 8'h00;
  localparam sc_byte_t ILLEGAL_RSP = 8'hFF;

  // sys_ctrl_host state encodings (visible on state_out)
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SEND_OP   = 3'd1;
  localparam logic [2:0] ST_SEND_AH   = 3'd2;
  localparam logic [2:0] ST_SEND_AL   = 3'd3;
  localparam logic [2:0] ST_SEND_DATA = 3'd4;
  localparam logic [2:0] ST_WAIT_RSP  = 3'd5;
  localparam logic [2:0] ST_RESP      = 3'd6;

  function automatic logic op_is_legal(input sc_byte_t op);
    return (op <= PING);
  endfunction

endpackage

// File: rtl/sys_ctrl_byte_sender.sv
// Turns a one-cycle send request into a single tx_start pulse, issued only
// while the transmitter is idle, and reports the matching tx_done.
module sys_ctrl_byte_sender (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_send,
  input  logic [7:0] i_data,
  input  logic       i_tx_active,
  input  logic       i_tx_done,
  output logic       o_tx_start,
  output logic [7:0] o_tx_data,
  output logic       o_done
);

  logic       r_pend;
  logic       r_start;
  logic       r_wait;
  logic [7:0] r_tx_data;
  logic       w_req;

  assign w_req = i_send | r_pend;

  // Hold the request until the transmitter is free; only our own byte's
  // tx_done is reported, so a done left over from before reset is ignored
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend    <= 1'b0;
      r_start   <= 1'b0;
      r_wait    <= 1'b0;
      r_tx_data <= '0;
    end else begin
      r_start <= w_req & ~i_tx_active;
      r_pend  <= w_req & i_tx_active;
      if (i_send)         r_tx_data <= i_data;
      if (r_start)        r_wait    <= 1'b1;
      else if (i_tx_done) r_wait    <= 1'b0;
    end
  end

  assign o_tx_start = r_start;
  assign o_tx_data  = r_tx_data;
  assign o_done     = r_wait & i_tx_done;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a two-flop input synchroniser and mid-bit sampling.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic       o_valid,
  output logic [7:0] o_data
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_MAX = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    r_sync;
  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_valid;
  logic [7:0]    r_data;
  logic          w_rx;
  logic          w_sample;

  assign w_rx     = r_sync[1];
  // Bit 0 is the start bit: sample it at half a bit, the rest a full bit apart
  assign w_sample = (r_bit == 4'd0) ? (r_cnt == HALF_MAX) : (r_cnt == FULL_MAX);

  // Frame detection, sampling and byte assembly; bad stop bit drops the byte
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= 2'b11;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_rx};
      r_valid <= 1'b0;
      if (!r_busy) begin
        if (!w_rx) begin
          r_busy <= 1'b1;
          r_cnt  <= '0;
          r_bit  <= '0;
        end
      end else if (w_sample) begin
        r_cnt <= '0;
        if (r_bit == 4'd0) begin
          if (w_rx) r_busy <= 1'b0;  // glitch, not a start bit
          else      r_bit  <= 4'd1;
        end else if (r_bit == 4'd9) begin
          r_busy <= 1'b0;
          if (w_rx) begin
            r_valid <= 1'b1;
            r_data  <= r_shift;
          end
        end else begin
          r_shift <= {w_rx, r_shift[7:1]};
          r_bit   <= r_bit + 4'd1;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. Deliberately has no reset: a byte in flight always
// completes, and an all-zero power-up state is idle with the line high.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_active,
  output logic       o_done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL_MAX = CW'(CLKS_PER_BIT - 1);

  logic          r_active;
  logic          r_done;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic [9:0]    r_shift;

  // Shift out start, 8 data bits LSB first, stop; done pulses as active drops
  always_ff @(posedge i_clk) begin
    r_done <= 1'b0;
    if (!r_active) begin
      if (i_start) begin
        r_shift  <= {1'b1, i_data, 1'b0};
        r_active <= 1'b1;
        r_cnt    <= '0;
        r_bit    <= '0;
      end
    end else if (r_cnt == FULL_MAX) begin
      r_cnt <= '0;
      if (r_bit == 4'd9) begin
        r_active <= 1'b0;
        r_done   <= 1'b1;
      end else begin
        r_bit   <= r_bit + 4'd1;
        r_shift <= {1'b1, r_shift[9:1]};
      end
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tx     = r_active ? r_shift[0] : 1'b1;
  assign o_active = r_active;
  assign o_done   = r_done;

endmodule

// File: rtl/sys_ctrl_host.sv
// Host-side initiator: serialises one command onto uart_tx, then waits for
// the single response byte (or a timeout) and reports it on the rsp_* port.
module sys_ctrl_host
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned TO_W           = 21,
  parameter int unsigned CLKS_PER_BIT   = 868
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [7:0]  i_cmd_op,
  input  logic [15:0] i_cmd_addr,
  input  logic [7:0]  i_cmd_data,
  output logic        o_rsp_valid,
  output logic [7:0]  o_rsp_data,
  output logic        o_rsp_timeout,
  output logic        o_rsp_nack,
  output logic        o_rx_drop,
  output logic        o_uart_tx,
  input  logic        i_uart_rx,
  output logic        o_busy,
  output logic [7:0]  o_state_out
);

  logic [2:0]      r_state;
  logic [2:0]      w_state_d;
  logic [7:0]      r_op;
  logic [15:0]     r_addr;
  logic [7:0]      r_data;
  logic [TO_W-1:0] r_to_cnt;
  logic [7:0]      r_rsp_data;
  logic            r_rsp_timeout;
  logic            r_rsp_nack;
  logic            r_rx_drop;

  logic            w_accept;
  logic            w_legal;
  logic            w_timeout;
  logic            w_send;
  logic [7:0]      w_send_data;
  logic            w_done;
  logic            w_tx_start;
  logic [7:0]      w_tx_data;
  logic            w_tx_active;
  logic            w_tx_done;
  logic            w_rx_valid;
  logic [7:0]      w_rx_data;

  assign w_accept  = i_cmd_valid && (r_state == ST_IDLE);
  assign w_legal   = op_is_legal(i_cmd_op);
  assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Next state and the byte to hand to the sender on each transition
  always_comb begin
    w_state_d   = r_state;
    w_send      = 1'b0;
    w_send_data = r_data;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_legal) begin
            w_state_d   = ST_SEND_OP;
            w_send      = 1'b1;
            w_send_data = i_cmd_op;
          end else begin
            w_state_d = ST_RESP;
          end
        end
      end
      ST_SEND_OP: begin
        if (w_done) begin
          if (r_op == WRITE_MEM || r_op == READ_MEM) begin
            w_state_d   = ST_SEND_AH;
            w_send      = 1'b1;
            w_send_data = r_addr[15:8];
          end else begin
            w_state_d = ST_WAIT_RSP;
          end
        end
      end
      ST_SEND_AH: begin
        if (w_done) begin
          w_state_d   = ST_SEND_AL;
          w_send      = 1'b1;
          w_send_data = r_addr[7:0];
        end
      end
      ST_SEND_AL: begin
        if (w_done) begin
          if (r_op == WRITE_MEM) begin
            w_state_d   = ST_SEND_DATA;
            w_send      = 1'b1;
            w_send_data = r_data;
          end else begin
            w_state_d = ST_WAIT_RSP;
          end
        end
      end
      ST_SEND_DATA: if (w_done) w_state_d = ST_WAIT_RSP;
      ST_WAIT_RSP:  if (w_rx_valid || w_timeout) w_state_d = ST_RESP;
      ST_RESP:      w_state_d = ST_IDLE;
      default:      w_state_d = ST_IDLE;
    endcase
  end

  // State, command latch, timeout counter and rx-drop pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_op      <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_to_cnt  <= '0;
      r_rx_drop <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_rx_drop <= w_rx_valid && (r_state != ST_WAIT_RSP);
      if (w_accept) begin
        r_op   <= i_cmd_op;
        r_addr <= i_cmd_addr;
        r_data <= i_cmd_data;
      end
      // WAIT_RSP lasts at most TIMEOUT_CYCLES cycles
      if (w_state_d == ST_WAIT_RSP && r_state != ST_WAIT_RSP) r_to_cnt <= '0;
      else if (r_state == ST_WAIT_RSP)                        r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Response fields; they hold until the next response is produced
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_data    <= '0;
      r_rsp_timeout <= 1'b0;
      r_rsp_nack    <= 1'b0;
    end else if (w_accept && !w_legal) begin
      r_rsp_data    <= ILLEGAL_RSP;
      r_rsp_timeout <= 1'b0;
      r_rsp_nack    <= 1'b1;
    end else if (r_state == ST_WAIT_RSP) begin
      if (w_rx_valid) begin  // a byte beats a simultaneous timeout
        r_rsp_data    <= w_rx_data;
        r_rsp_timeout <= 1'b0;
        r_rsp_nack    <= (r_op != READ_MEM) && (w_rx_data != ACK_BYTE);
      end else if (w_timeout) begin
        r_rsp_data    <= '0;
        r_rsp_timeout <= 1'b1;
        r_rsp_nack    <= 1'b0;
      end
    end
  end

  sys_ctrl_byte_sender u_sender (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_send      (w_send),
    .i_data      (w_send_data),
    .i_tx_active (w_tx_active),
    .i_tx_done   (w_tx_done),
    .o_tx_start  (w_tx_start),
    .o_tx_data   (w_tx_data),
    .o_done      (w_done)
  );

  uart_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx (
    .i_clk    (i_clk),
    .i_start  (w_tx_start),
    .i_data   (w_tx_data),
    .o_tx     (o_uart_tx),
    .o_active (w_tx_active),
    .o_done   (w_tx_done)
  );

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_rx (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_rx    (i_uart_rx),
    .o_valid (w_rx_valid),
    .o_data  (w_rx_data)
  );

  assign o_cmd_ready   = (r_state == ST_IDLE);
  assign o_busy        = ~o_cmd_ready;
  assign o_rsp_valid   = (r_state == ST_RESP);
  assign o_rsp_data    = r_rsp_data;
  assign o_rsp_timeout = r_rsp_timeout;
  assign o_rsp_nack    = r_rsp_nack;
  assign o_rx_drop     = r_rx_drop;
  assign o_state_out   = {5'd0, r_state};

endmodule

// File: tb/tb_sys_ctrl_host.sv
// Self-checking bench for sys_ctrl_host: table-driven commands with a tx-byte
// and response scoreboard, plus hand sequences for back-to-back, stray rx and
// reset in the middle of a command.
module tb_sys_ctrl_host;

  localparam int unsigned CPB = 8;
  localparam int unsigned TMO = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_op = 8'h00;
  logic [15:0] cmd_addr = 16'h0000;
  logic [7:0]  cmd_data = 8'h00;
  logic        uart_rx = 1'b1;
  logic        cmd_ready, rsp_valid, rsp_timeout, rsp_nack, rx_drop, uart_tx, busy;
  logic [7:0]  rsp_data, state_out;

  int errors = 0;
  int checks = 0;
  int tx_seen = 0;
  int rsp_seen = 0;
  int drop_seen = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       to;
    logic       nack;
  } rsp_t;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] addr;
    logic [7:0]  data;
    bit          reply_en;
    logic [7:0]  reply;
    logic [7:0]  e_data;
    bit          e_to;
    bit          e_nack;
  } vec_t;

  logic [7:0] exp_tx[$];
  rsp_t       exp_rsp[$];
  logic [7:0] mon_b;
  rsp_t       mon_e;
  logic       prev_valid = 1'b0;

  always #5 clk = ~clk;

  sys_ctrl_host #(
    .TIMEOUT_CYCLES (TMO),
    .TO_W           (10),
    .CLKS_PER_BIT   (CPB)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cmd_op      (cmd_op),
    .i_cmd_addr    (cmd_addr),
    .i_cmd_data    (cmd_data),
    .o_rsp_valid   (rsp_valid),
    .o_rsp_data    (rsp_data),
    .o_rsp_timeout (rsp_timeout),
    .o_rsp_nack    (rsp_nack),
    .o_rx_drop     (rx_drop),
    .o_uart_tx     (uart_tx),
    .i_uart_rx     (uart_rx),
    .o_busy        (busy),
    .o_state_out   (state_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Decode bytes on uart_tx and compare against the expected byte queue
  initial begin
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          mon_b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        check("tx stop bit", {31'd0, uart_tx}, 32'd1);
        tx_seen++;
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx unexpected byte: got %02h, required none", mon_b);
        end else begin
          check("tx byte", {24'd0, mon_b}, {24'd0, exp_tx.pop_front()});
        end
      end
    end
  end

  // Response scoreboard and rx_drop pulse counter
  initial begin
    forever begin
      @(negedge clk);
      if (prev_valid) check("rsp_valid one cycle", {31'd0, rsp_valid}, 32'd0);
      if (rsp_valid === 1'b1 && !prev_valid) begin
        rsp_seen++;
        if (exp_rsp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp unexpected: got data %02h, required no response", rsp_data);
        end else begin
          mon_e = exp_rsp.pop_front();
          check("rsp_data", {24'd0, rsp_data}, {24'd0, mon_e.data});
          check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, mon_e.to});
          check("rsp_nack", {31'd0, rsp_nack}, {31'd0, mon_e.nack});
        end
      end
      if (rx_drop === 1'b1) drop_seen++;
      prev_valid = (rsp_valid === 1'b1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic send_rx(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic push_tx(input vec_t v);
    if (v.op > 8'h05) return;
    exp_tx.push_back(v.op);
    if (v.op == 8'h02 || v.op == 8'h03) begin
      exp_tx.push_back(v.addr[15:8]);
      exp_tx.push_back(v.addr[7:0]);
    end
    if (v.op == 8'h02) exp_tx.push_back(v.data);
  endtask

  task automatic wait_state(input logic [7:0] st, input int budget, input string name);
    int n = 0;
    while (state_out !== st && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {24'd0, state_out}, {24'd0, st});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (state_out !== 8'd0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("return to IDLE", {24'd0, state_out}, 32'd0);
    check("cmd_ready in IDLE", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    int t0;
    wait_idle();
    t0 = tx_seen;
    push_tx(v);
    exp_rsp.push_back('{v.e_data, v.e_to, v.e_nack});
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_addr  = v.addr;
    cmd_data  = v.data;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy after accept", {31'd0, busy}, 32'd1);
    if (v.op > 8'h05) begin
      check("illegal rsp latency", {31'd0, rsp_valid}, 32'd1);
      repeat (12 * CPB) @(negedge clk);
      check("illegal op no tx", tx_seen - t0, 32'd0);
    end else begin
      @(negedge clk);
      check("first tx_start latency", {31'd0, uart_tx}, 32'd0);
      wait_state(8'd5, 600, "reach WAIT_RSP");
      if (v.reply_en) begin
        send_rx(v.reply);
      end else begin
        n = 0;
        while (state_out === 8'd5 && n < int'(TMO) + 100) begin
          @(negedge clk);
          n++;
        end
        check("timeout wait cycles", n, TMO);
      end
    end
    wait_idle();
    check("tx bytes outstanding", exp_tx.size(), 32'd0);
    check("rsp outstanding", exp_rsp.size(), 32'd0);
    check("rsp_data held", {24'd0, rsp_data}, {24'd0, v.e_data});
    check("rsp_nack held", {31'd0, rsp_nack}, {31'd0, v.e_nack});
  endtask

  vec_t vecs[11];
  vec_t ping_v;

  initial begin
    int t0;
    int d0;
    int r0;
    int n;

    //            op     addr      data   rep  reply  e_data to nack
    vecs[0]  = '{8'h05, 16'h0000, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{8'h02, 16'h8000, 8'hA5, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{8'h03, 16'h1234, 8'h00, 1'b1, 8'h3C, 8'h3C, 1'b0, 1'b0};
    vecs[3]  = '{8'h00, 16'h0000, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[4]  = '{8'h00, 16'h0000, 8'h00, 1'b1, 8'h7F, 8'h7F, 1'b0, 1'b1};
    vecs[5]  = '{8'h09, 16'h0000, 8'h00, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b1};
    vecs[6]  = '{8'h03, 16'hBEEF, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{8'h01, 16'h0000, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[8]  = '{8'h04, 16'h0000, 8'h00, 1'b1, 8'h01, 8'h01, 1'b0, 1'b1};
    vecs[9]  = '{8'h03, 16'h00FF, 8'h00, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0};
    vecs[10] = '{8'h02, 16'h4321, 8'h5A, 1'b1, 8'h55, 8'h55, 1'b0, 1'b1};
    ping_v   = '{8'h05, 16'h0000, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};

    // Reset values
    repeat (3) @(negedge clk);
    check("reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset rsp_data", {24'd0, rsp_data}, 32'd0);
    check("reset rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    check("reset rsp_nack", {31'd0, rsp_nack}, 32'd0);
    check("reset rx_drop", {31'd0, rx_drop}, 32'd0);
    check("reset state", {24'd0, state_out}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Reset while the AL byte of a read is on the wire
    wait_idle();
    exp_tx.push_back(8'h03);
    exp_tx.push_back(8'h12);
    exp_tx.push_back(8'h34);
    cmd_valid = 1'b1;
    cmd_op    = 8'h03;
    cmd_addr  = 16'h1234;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_state(8'd3, 600, "reach SEND_AL");
    repeat (3 * CPB) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midop reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("midop reset busy", {31'd0, busy}, 32'd0);
    check("midop reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midop reset rsp_data", {24'd0, rsp_data}, 32'd0);
    check("midop reset rsp_nack", {31'd0, rsp_nack}, 32'd0);
    check("midop reset rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    check("midop reset state", {24'd0, state_out}, 32'd0);
    rst_n = 1'b1;
    n = 0;
    while (exp_tx.size() != 0 && n < int'(20 * CPB)) begin
      @(negedge clk);
      n++;
    end
    check("in-flight byte completes", exp_tx.size(), 32'd0);
    t0 = tx_seen;
    repeat (25 * CPB) @(negedge clk);
    check("no tx_start after reset", tx_seen - t0, 32'd0);
    check("idle after reset", {24'd0, state_out}, 32'd0);
    run_vec(ping_v);

    // Back-to-back: illegal op, then a held ping accepted right after rsp_valid
    wait_idle();
    exp_rsp.push_back('{8'hFF, 1'b0, 1'b1});
    exp_tx.push_back(8'h05);
    exp_rsp.push_back('{8'h00, 1'b0, 1'b0});
    cmd_valid = 1'b1;
    cmd_op    = 8'h09;
    @(negedge clk);
    check("b2b illegal rsp_valid", {31'd0, rsp_valid}, 32'd1);
    cmd_op = 8'h05;
    @(negedge clk);
    check("b2b cmd_ready after rsp", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("b2b ping accepted", {24'd0, state_out}, 32'd1);
    // A request while busy must be ignored
    cmd_valid = 1'b1;
    cmd_op    = 8'h04;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_state(8'd5, 600, "b2b reach WAIT_RSP");
    send_rx(8'h00);
    wait_idle();
    repeat (12 * CPB) @(negedge clk);
    check("b2b tx outstanding", exp_tx.size(), 32'd0);
    check("b2b rsp outstanding", exp_rsp.size(), 32'd0);

    // Stray rx byte in IDLE
    d0 = drop_seen;
    r0 = rsp_seen;
    send_rx(8'h5A);
    repeat (4 * CPB) @(negedge clk);
    check("stray rx_drop pulses", drop_seen - d0, 32'd1);
    check("stray rx no rsp", rsp_seen - r0, 32'd0);
    check("stray rx stays IDLE", {24'd0, state_out}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
